// File: rtl/reg_write_decoder_if.sv
// Write-port bundle between the write-back stage and the register-file write decoder.
// The master issues write requests and clears; the slave returns staging and commit status.
interface reg_write_decoder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             wr_en;
   logic [3:0]       wr_sel;
   logic [WIDTH-1:0] wr_data;
   logic             clr;
   logic [15:0]      wr_onehot;
   logic             pend_valid;
   logic [3:0]       pend_sel;
   logic [WIDTH-1:0] pend_data;
   logic             wr_ack;
   logic             wr_err;

   modport master (
      output wr_en, wr_sel, wr_data, clr,
      input  wr_onehot, pend_valid, pend_sel, pend_data, wr_ack, wr_err
   );

   modport slave (
      input  wr_en, wr_sel, wr_data, clr,
      output wr_onehot, pend_valid, pend_sel, pend_data, wr_ack, wr_err
   );
endinterface

// File: rtl/reg_write_decoder.sv
// Register-file write side: one staging register feeding a 4-to-16 one-hot commit decode
// into 16 storage registers, with ack/err pulses and the staged write exposed for forwarding.
module reg_write_decoder #(
   parameter int unsigned WIDTH   = 16,
   parameter logic [15:0] RO_MASK = 16'h0001
) (
   input  logic                  clk,
   input  logic                  reset_n,
   reg_write_decoder_if.slave    bus,
   output logic [WIDTH-1:0]      r0,
   output logic [WIDTH-1:0]      r1,
   output logic [WIDTH-1:0]      r2,
   output logic [WIDTH-1:0]      r3,
   output logic [WIDTH-1:0]      r4,
   output logic [WIDTH-1:0]      r5,
   output logic [WIDTH-1:0]      r6,
   output logic [WIDTH-1:0]      r7,
   output logic [WIDTH-1:0]      r8,
   output logic [WIDTH-1:0]      r9,
   output logic [WIDTH-1:0]      r10,
   output logic [WIDTH-1:0]      r11,
   output logic [WIDTH-1:0]      r12,
   output logic [WIDTH-1:0]      r13,
   output logic [WIDTH-1:0]      r14,
   output logic [WIDTH-1:0]      r15
);

   logic [WIDTH-1:0] regs_q [16];
   logic             pend_valid_q;
   logic [3:0]       pend_sel_q;
   logic [WIDTH-1:0] pend_data_q;
   logic             wr_ack_q;
   logic             wr_err_q;
   logic [15:0]      commit_onehot;
   logic             commit_ro;

   // Read-only targets never decode, so no write path to them exists at all.
   always_comb begin
      commit_onehot = '0;
      if (pend_valid_q) begin
         commit_onehot = (16'(1) << pend_sel_q) & ~RO_MASK;
      end
   end

   assign commit_ro = RO_MASK[pend_sel_q];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= '0;
         end
         pend_valid_q <= 1'b0;
         pend_sel_q   <= '0;
         pend_data_q  <= '0;
         wr_ack_q     <= 1'b0;
         wr_err_q     <= 1'b0;
      end else if (bus.clr) begin
         // Clear drops the staged write silently and ignores any request this cycle.
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= '0;
         end
         pend_valid_q <= 1'b0;
         wr_ack_q     <= 1'b0;
         wr_err_q     <= 1'b0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (commit_onehot[i]) begin
               regs_q[i] <= pend_data_q;
            end
         end
         wr_ack_q     <= pend_valid_q & ~commit_ro;
         wr_err_q     <= pend_valid_q & commit_ro;
         pend_valid_q <= bus.wr_en;
         if (bus.wr_en) begin
            pend_sel_q  <= bus.wr_sel;
            pend_data_q <= bus.wr_data;
         end
      end
   end

   assign bus.wr_onehot  = commit_onehot;
   assign bus.pend_valid = pend_valid_q;
   assign bus.pend_sel   = pend_sel_q;
   assign bus.pend_data  = pend_data_q;
   assign bus.wr_ack     = wr_ack_q;
   assign bus.wr_err     = wr_err_q;

   assign r0  = regs_q[0];
   assign r1  = regs_q[1];
   assign r2  = regs_q[2];
   assign r3  = regs_q[3];
   assign r4  = regs_q[4];
   assign r5  = regs_q[5];
   assign r6  = regs_q[6];
   assign r7  = regs_q[7];
   assign r8  = regs_q[8];
   assign r9  = regs_q[9];
   assign r10 = regs_q[10];
   assign r11 = regs_q[11];
   assign r12 = regs_q[12];
   assign r13 = regs_q[13];
   assign r14 = regs_q[14];
   assign r15 = regs_q[15];

endmodule

// File: tb/tb_reg_write_decoder.sv
// Directed bench for reg_write_decoder: staging, commit latency, RO rejection, clear and
// asynchronous reset behaviour, all against hand-computed expectations.
module tb_reg_write_decoder;

   localparam int unsigned WIDTH = 16;

   logic clk;
   logic reset_n;
   logic [WIDTH-1:0] r0, r1, r2, r3, r4, r5, r6, r7;
   logic [WIDTH-1:0] r8, r9, r10, r11, r12, r13, r14, r15;
   logic [WIDTH-1:0] rv [16];

   int checks;
   int failures;

   reg_write_decoder_if #(.WIDTH(WIDTH)) bus ();

   reg_write_decoder #(
      .WIDTH  (WIDTH),
      .RO_MASK(16'h0001)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus),
      .r0     (r0),
      .r1     (r1),
      .r2     (r2),
      .r3     (r3),
      .r4     (r4),
      .r5     (r5),
      .r6     (r6),
      .r7     (r7),
      .r8     (r8),
      .r9     (r9),
      .r10    (r10),
      .r11    (r11),
      .r12    (r12),
      .r13    (r13),
      .r14    (r14),
      .r15    (r15)
   );

   always_comb begin
      rv[0]  = r0;  rv[1]  = r1;  rv[2]  = r2;  rv[3]  = r3;
      rv[4]  = r4;  rv[5]  = r5;  rv[6]  = r6;  rv[7]  = r7;
      rv[8]  = r8;  rv[9]  = r9;  rv[10] = r10; rv[11] = r11;
      rv[12] = r12; rv[13] = r13; rv[14] = r14; rv[15] = r15;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic [3:0] sel, input logic [WIDTH-1:0] data,
                        input logic clear);
      bus.wr_en   = en;
      bus.wr_sel  = sel;
      bus.wr_data = data;
      bus.clr     = clear;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      drive(1'b0, 4'd0, 16'h0000, 1'b0);
      tick();
      tick();
      reset_n = 1'b1;

      check("rst_pend_valid", 32'(bus.pend_valid), 32'h0);
      check("rst_ack", 32'(bus.wr_ack), 32'h0);
      check("rst_err", 32'(bus.wr_err), 32'h0);
      check("rst_onehot", 32'(bus.wr_onehot), 32'h0);
      check("rst_r5", 32'(r5), 32'h0);

      // Preload r1 and r15 back to back.
      drive(1'b1, 4'd1, 16'hAAAA, 1'b0);
      tick();
      check("pre_pend_sel", 32'(bus.pend_sel), 32'h1);
      check("pre_onehot_r1", 32'(bus.wr_onehot), 32'h0002);
      drive(1'b1, 4'd15, 16'h5555, 1'b0);
      tick();
      check("pre_r1", 32'(r1), 32'hAAAA);
      check("pre_ack1", 32'(bus.wr_ack), 32'h1);
      check("pre_onehot_r15", 32'(bus.wr_onehot), 32'h8000);
      drive(1'b0, 4'd0, 16'h0000, 1'b0);
      tick();
      check("pre_r15", 32'(r15), 32'h5555);
      check("pre_ack2", 32'(bus.wr_ack), 32'h1);
      check("pre_r1_hold", 32'(r1), 32'hAAAA);
      tick();
      check("pre_ack_drop", 32'(bus.wr_ack), 32'h0);

      // Asynchronous reset clears everything without a clock edge.
      reset_n = 1'b0;
      #1;
      check("async_r1", 32'(r1), 32'h0);
      check("async_r15", 32'(r15), 32'h0);
      check("async_pend_valid", 32'(bus.pend_valid), 32'h0);
      check("async_ack", 32'(bus.wr_ack), 32'h0);
      tick();
      reset_n = 1'b1;

      // Single write: two-edge latency, one-cycle ack.
      drive(1'b1, 4'd5, 16'hBEEF, 1'b0);
      tick();
      check("w5_pend_valid", 32'(bus.pend_valid), 32'h1);
      check("w5_pend_data", 32'(bus.pend_data), 32'hBEEF);
      check("w5_r5_early", 32'(r5), 32'h0);
      check("w5_ack_early", 32'(bus.wr_ack), 32'h0);
      check("w5_onehot", 32'(bus.wr_onehot), 32'h0020);
      drive(1'b0, 4'd9, 16'h1111, 1'b0);
      tick();
      check("w5_r5", 32'(r5), 32'hBEEF);
      check("w5_ack", 32'(bus.wr_ack), 32'h1);
      check("w5_pend_idle", 32'(bus.pend_valid), 32'h0);
      check("w5_pend_sel_hold", 32'(bus.pend_sel), 32'h5);
      check("w5_pend_data_hold", 32'(bus.pend_data), 32'hBEEF);
      check("w5_onehot_idle", 32'(bus.wr_onehot), 32'h0);
      tick();
      check("w5_ack_drop", 32'(bus.wr_ack), 32'h0);
      check("w5_r5_hold", 32'(r5), 32'hBEEF);

      // Back-to-back writes to the same index commit in order.
      drive(1'b1, 4'd3, 16'h0001, 1'b0);
      tick();
      drive(1'b1, 4'd3, 16'h0002, 1'b0);
      tick();
      check("b2b_r3_1", 32'(r3), 32'h1);
      check("b2b_ack_1", 32'(bus.wr_ack), 32'h1);
      drive(1'b1, 4'd3, 16'h0003, 1'b0);
      tick();
      check("b2b_r3_2", 32'(r3), 32'h2);
      check("b2b_ack_2", 32'(bus.wr_ack), 32'h1);
      drive(1'b0, 4'd0, 16'h0000, 1'b0);
      tick();
      check("b2b_r3_3", 32'(r3), 32'h3);
      check("b2b_ack_3", 32'(bus.wr_ack), 32'h1);
      tick();
      check("b2b_ack_drop", 32'(bus.wr_ack), 32'h0);
      for (int i = 0; i < 16; i++) begin
         if (i != 3 && i != 5) check($sformatf("b2b_other_r%0d", i), 32'(rv[i]), 32'h0);
      end
      check("b2b_r5_keep", 32'(r5), 32'hBEEF);

      // Write to read-only r0 is rejected.
      drive(1'b1, 4'd0, 16'hFFFF, 1'b0);
      tick();
      check("ro_pend_valid", 32'(bus.pend_valid), 32'h1);
      check("ro_onehot", 32'(bus.wr_onehot), 32'h0);
      drive(1'b0, 4'd0, 16'h0000, 1'b0);
      tick();
      check("ro_r0", 32'(r0), 32'h0);
      check("ro_err", 32'(bus.wr_err), 32'h1);
      check("ro_ack", 32'(bus.wr_ack), 32'h0);
      tick();
      check("ro_err_drop", 32'(bus.wr_err), 32'h0);
      check("ro_r0_hold", 32'(r0), 32'h0);

      // Clear drops the staged write and ignores the same-cycle request.
      drive(1'b1, 4'd7, 16'h1234, 1'b0);
      tick();
      check("clr_staged", 32'(bus.pend_valid), 32'h1);
      drive(1'b1, 4'd8, 16'h5678, 1'b1);
      tick();
      check("clr_pend_valid", 32'(bus.pend_valid), 32'h0);
      check("clr_ack", 32'(bus.wr_ack), 32'h0);
      check("clr_r7", 32'(r7), 32'h0);
      check("clr_r3", 32'(r3), 32'h0);
      check("clr_r5", 32'(r5), 32'h0);
      drive(1'b0, 4'd0, 16'h0000, 1'b0);
      tick();
      check("clr_ack_after", 32'(bus.wr_ack), 32'h0);
      check("clr_r7_after", 32'(r7), 32'h0);
      check("clr_r8_after", 32'(r8), 32'h0);

      // Reset pulse while a write is staged loses it without an ack.
      drive(1'b1, 4'd9, 16'h9999, 1'b0);
      tick();
      check("rstp_staged", 32'(bus.pend_valid), 32'h1);
      drive(1'b0, 4'd0, 16'h0000, 1'b0);
      reset_n = 1'b0;
      #1;
      check("rstp_pend_valid", 32'(bus.pend_valid), 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      check("rstp_r9", 32'(r9), 32'h0);
      check("rstp_ack", 32'(bus.wr_ack), 32'h0);
      tick();
      check("rstp_ack_late", 32'(bus.wr_ack), 32'h0);
      check("rstp_r9_late", 32'(r9), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
